// File: rtl/resource_credit_bp_pkg.sv
// Shared types and elaboration helpers for resource_credit_bp.
// Optional feature macro used by the top: RESOURCE_CREDIT_LAT_CHK_EN.
package resource_credit_pkg;

    localparam int RSP_DAT_BITS = 64;
    localparam int RSP_CTL_BITS = 16;

    // Result entry at the default widths; the top builds a width-matched copy
    // of the same {dat, ctl} layout for its own parameters.
    typedef struct packed {
        logic [RSP_DAT_BITS-1:0] dat;
        logic [RSP_CTL_BITS-1:0] ctl;
    } rsp_t;

    // Credit counter width: must hold the value FIFO_DEPTH itself.
    function automatic int cred_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // FIFO_DEPTH must be a power of 2 (and at least 2) so the pointer MSB
    // trick distinguishes full from empty.
    function automatic bit is_pow2(input int n);
        return (n > 1) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/resource_credit_bp_if.sv
// Single-channel stream interface used on both sides of resource_credit_bp.
//
// Handshake: a beat transfers on a rising clock edge where val && rdy are
// both high. Once the source raises val it holds val and the payload stable
// until the transfer happens; rdy may change freely and the source must not
// wait for rdy before asserting val.
interface if_axi_stream #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 16,
    parameter int MOD_BITS = 3
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;

    modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);

    // Aliases for code written in master/slave terms.
    modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/resource_credit_bp_fifo.sv
// credit_fifo: first-word-fall-through synchronous FIFO with occupancy count.
// Pointers carry one extra MSB so full and empty are distinguishable.
// Writes while full are dropped; reads while empty are ignored.
module credit_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count
);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         wr_ok;
    logic         rd_ok;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (count == DEPTH_C);
    assign wr_ok  = wr_en && !full;
    assign rd_ok  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    // Pointer advance; write and read in the same cycle both take effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// File: rtl/resource_credit_bp.sv
// resource_credit_bp: wraps a fixed-latency, non-stallable resource so it can
// live behind a backpressured stream. Requests issue only while credits
// remain; every credit reserves one result FIFO slot, so results are never
// dropped even when the downstream side stalls.
// Optional feature macro: RESOURCE_CREDIT_LAT_CHK_EN compiles in a checker
// that flags results arriving off the expected latency or with a wrong tag.
module resource_credit_bp
    import resource_credit_pkg::*;
#(
    parameter int DAT_BITS    = RSP_DAT_BITS,
    parameter int CTL_BITS    = RSP_CTL_BITS,
    parameter int RES_LATENCY = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    if_axi_stream.sink          i_axi,
    if_axi_stream.source        o_axi,
    output logic                o_req_val,
    output logic [DAT_BITS-1:0] o_req_dat,
    output logic [CTL_BITS-1:0] o_req_ctl,
    input  logic                i_rsp_val,
    input  logic [DAT_BITS-1:0] i_rsp_dat,
    input  logic [CTL_BITS-1:0] i_rsp_ctl,
    output logic                o_err
);
    localparam int              CB         = cred_bits(FIFO_DEPTH);
    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam logic [CB-1:0]   CRED_INIT  = CB'(FIFO_DEPTH);
    localparam logic [CB-1:0]   CRED_ONE   = CB'(1);

    typedef struct packed {
        logic [DAT_BITS-1:0] dat;
        logic [CTL_BITS-1:0] ctl;
    } entry_t;

    if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $error("resource_credit_bp: FIFO_DEPTH must be a power of 2");
    end
    if (RES_LATENCY < 1) begin : g_bad_latency
        $error("resource_credit_bp: RES_LATENCY must be at least 1");
    end

    logic [CB-1:0] cred;
    logic          rdy_q;
    logic          issue;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    entry_t        wr_entry;
    entry_t        head;
    logic          ovf;
    logic          lat_err;

    assign issue = i_axi.val && rdy_q;
    assign pop   = o_axi.val && o_axi.rdy;

    // Request side: issue goes straight through to the resource.
    assign i_axi.rdy = rdy_q;
    assign o_req_val = issue;
    assign o_req_dat = i_axi.dat;
    assign o_req_ctl = i_axi.ctl;

    // Credit counter; rdy_q is kept equal to (cred != 0) as a register so the
    // upstream ready never depends combinationally on downstream ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cred  <= CRED_INIT;
            rdy_q <= 1'b1;
        end else begin
            case ({issue, pop})
                2'b10: begin
                    cred  <= cred - CRED_ONE;
                    rdy_q <= (cred != CRED_ONE);
                end
                2'b01: begin
                    cred  <= cred + CRED_ONE;
                    rdy_q <= 1'b1;
                end
                default: begin
                    cred  <= cred;
                    rdy_q <= rdy_q;
                end
            endcase
        end
    end

    assign wr_entry.dat = i_rsp_dat;
    assign wr_entry.ctl = i_rsp_ctl;

    credit_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .rst    (i_rst),
        .wr_en  (i_rsp_val),
        .wr_dat (wr_entry),
        .rd_en  (o_axi.rdy),
        .rd_dat (head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    // Result side: FIFO head is presented as a single-beat packet.
    assign o_axi.val = !fifo_empty;
    assign o_axi.dat = head.dat;
    assign o_axi.ctl = head.ctl;
    assign o_axi.sop = 1'b1;
    assign o_axi.eop = 1'b1;
    assign o_axi.err = 1'b0;
    assign o_axi.mod = '0;

    // A result with no free slot means the resource returned something that
    // was never credited.
    assign ovf = i_rsp_val && fifo_full;

`ifdef RESOURCE_CREDIT_LAT_CHK_EN
    logic [RES_LATENCY-1:0] iss_sr;
    logic [CTL_BITS-1:0]    ctl_sr [RES_LATENCY];

    // Delayed copy of issue strobes, aligned to when results must return.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            iss_sr <= '0;
        end else begin
            iss_sr[0] <= issue;
            for (int i = 1; i < RES_LATENCY; i++) iss_sr[i] <= iss_sr[i-1];
        end
    end

    // Delayed copy of issued tags, compared only where a result is expected.
    always_ff @(posedge i_clk) begin
        ctl_sr[0] <= i_axi.ctl;
        for (int i = 1; i < RES_LATENCY; i++) ctl_sr[i] <= ctl_sr[i-1];
    end

    assign lat_err = (i_rsp_val != iss_sr[RES_LATENCY-1]) ||
                     (i_rsp_val && iss_sr[RES_LATENCY-1] &&
                      (i_rsp_ctl != ctl_sr[RES_LATENCY-1]));
`else
    assign lat_err = 1'b0;
`endif

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (ovf || lat_err) begin
            o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_resource_credit_bp.sv
// Testbench for resource_credit_bp: directed scenarios plus a randomly
// backpressured stream, with a behavioural fixed-latency resource model.
module tb_resource_credit_bp;
    import resource_credit_pkg::*;

    localparam int DW    = 64;
    localparam int CW    = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int RW    = $bits(rsp_t);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          o_req_val;
    logic [DW-1:0] o_req_dat;
    logic [CW-1:0] o_req_ctl;
    logic          rsp_val;
    logic [DW-1:0] rsp_dat;
    logic [CW-1:0] rsp_ctl;
    logic          o_err;

    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) in_if ();
    if_axi_stream #(.DAT_BITS(DW), .CTL_BITS(CW)) out_if ();

    resource_credit_bp #(
        .DAT_BITS(DW), .CTL_BITS(CW), .RES_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_axi(in_if), .o_axi(out_if),
        .o_req_val(o_req_val), .o_req_dat(o_req_dat), .o_req_ctl(o_req_ctl),
        .i_rsp_val(rsp_val), .i_rsp_dat(rsp_dat), .i_rsp_ctl(rsp_ctl),
        .o_err(o_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_issue  = 0;
    int n_pop    = 0;
    logic [RW-1:0] exp_q[$];

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        in_if.val   = 1'b0;
        out_if.rdy  = 1'b1;
        inj_val     = 1'b0;
        extra       = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- resource model ----------------
    logic [LAT-1:0] p_val;
    logic [DW-1:0]  p_dat [LAT];
    logic [CW-1:0]  p_ctl [LAT];
    logic           extra = 1'b0;
    logic           late_val;
    logic [DW-1:0]  late_dat;
    logic [CW-1:0]  late_ctl;
    logic           inj_val = 1'b0;
    logic [DW-1:0]  inj_dat = '0;
    logic [CW-1:0]  inj_ctl = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_val    <= '0;
            late_val <= 1'b0;
        end else begin
            p_val    <= {p_val[LAT-2:0], o_req_val};
            p_dat[0] <= o_req_dat;
            p_ctl[0] <= o_req_ctl;
            for (int i = 1; i < LAT; i++) begin
                p_dat[i] <= p_dat[i-1];
                p_ctl[i] <= p_ctl[i-1];
            end
            late_val <= p_val[LAT-1] && extra;
            late_dat <= p_dat[LAT-1];
            late_ctl <= p_ctl[LAT-1];
        end
    end

    assign rsp_val = (p_val[LAT-1] && !extra) || late_val || inj_val;
    assign rsp_dat = inj_val ? inj_dat : (late_val ? late_dat : p_dat[LAT-1]);
    assign rsp_ctl = inj_val ? inj_ctl : (late_val ? late_ctl : p_ctl[LAT-1]);

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic          iss;
        logic [RW-1:0] e;
        int            infl;
        #4;
        if (!rst) begin
            iss = in_if.val && in_if.rdy;
            checks++;
            if (o_req_val !== iss) begin
                failures++;
                $display("FAIL req_val: got %0b expected %0b", o_req_val, iss);
            end
            if (iss) begin
                exp_q.push_back({in_if.dat, in_if.ctl});
                n_issue++;
                checks++;
                if (o_req_dat !== in_if.dat || o_req_ctl !== in_if.ctl) begin
                    failures++;
                    $display("FAIL req_payload: got %0h/%0h expected %0h/%0h",
                             o_req_dat, o_req_ctl, in_if.dat, in_if.ctl);
                end
            end
            if (out_if.val && out_if.rdy) begin
                n_pop++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: got %0h/%0h expected none",
                             out_if.dat, out_if.ctl);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_if.dat, out_if.ctl} !== e) begin
                        failures++;
                        $display("FAIL result_order: got %0h/%0h expected %0h/%0h",
                                 out_if.dat, out_if.ctl, e[RW-1:CW], e[CW-1:0]);
                    end
                end
            end
            infl = $countones(p_val) + int'(late_val);
            checks++;
            if (int'(dut.cred) + infl + int'(dut.fifo_count) != DEPTH) begin
                failures++;
                $display("FAIL invariant: got cred=%0d inflight=%0d count=%0d expected sum %0d",
                         dut.cred, infl, dut.fifo_count, DEPTH);
            end
        end
    end

    // Wait (bounded) until nothing remains buffered or expected.
    task automatic drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || out_if.val) && cyc < 200) begin
            @(negedge clk);
            #4;
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #4;
        checks++;
        if (in_if.rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy: got %0b expected 1", in_if.rdy); end
        checks++;
        if (out_if.val !== 1'b0) begin failures++; $display("FAIL reset_out_val: got %0b expected 0", out_if.val); end
        checks++;
        if (o_req_val !== 1'b0) begin failures++; $display("FAIL reset_req_val: got %0b expected 0", o_req_val); end
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", o_err); end
        checks++;
        if (dut.cred !== 4'd8) begin failures++; $display("FAIL reset_cred: got %0d expected 8", dut.cred); end
    endtask

    task automatic test_single();
        @(negedge clk);
        out_if.rdy = 1'b1;
        in_if.val  = 1'b1;
        in_if.dat  = 64'h5;
        in_if.ctl  = 16'h3;
        #4;
        checks++;
        if (o_req_val !== 1'b1) begin failures++; $display("FAIL single_issue: got %0b expected 1", o_req_val); end
        @(negedge clk);
        in_if.val = 1'b0;
        in_if.dat = '0;
        in_if.ctl = '0;
        #4;
        checks++;
        if (dut.cred !== 4'd7) begin failures++; $display("FAIL single_cred_taken: got %0d expected 7", dut.cred); end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            #4;
            checks++;
            if (out_if.val !== 1'b0) begin failures++; $display("FAIL single_early_val: got %0b expected 0 at cycle %0d", out_if.val, c); end
        end
        @(negedge clk);
        #4;
        checks++;
        if (out_if.val !== 1'b1 || out_if.dat !== 64'h5 || out_if.ctl !== 16'h3) begin
            failures++;
            $display("FAIL single_result: got val=%0b %0h/%0h expected val=1 5/3", out_if.val, out_if.dat, out_if.ctl);
        end
        checks++;
        if (out_if.sop !== 1'b1 || out_if.eop !== 1'b1 || out_if.err !== 1'b0 || out_if.mod !== 3'd0) begin
            failures++;
            $display("FAIL single_sideband: got sop=%0b eop=%0b err=%0b mod=%0d expected 1 1 0 0",
                     out_if.sop, out_if.eop, out_if.err, out_if.mod);
        end
        @(negedge clk);
        #4;
        checks++;
        if (dut.cred !== 4'd8) begin failures++; $display("FAIL single_cred_back: got %0d expected 8", dut.cred); end
    endtask

    task automatic test_stream();
        int drops = 0;
        int pops0 = n_pop;
        out_if.rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_if.val = 1'b1;
            in_if.dat = 64'(i * 7 + 100);
            in_if.ctl = 16'(i);
            #4;
            if (in_if.rdy !== 1'b1) drops++;
        end
        @(negedge clk);
        in_if.val = 1'b0;
        drain("stream");
        checks++;
        if (drops != 0) begin failures++; $display("FAIL stream_rdy_drop: got %0d expected 0", drops); end
        checks++;
        if (n_pop - pops0 != 100) begin failures++; $display("FAIL stream_count: got %0d expected 100", n_pop - pops0); end
    endtask

    task automatic test_backpressure();
        int acc   = 0;
        int pops0;
        @(negedge clk);
        out_if.rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            in_if.val = 1'b1;
            in_if.dat = 64'hA000 + 64'(i);
            in_if.ctl = 16'h100 + 16'(i);
            #4;
            if (in_if.rdy === 1'b1) acc++;
        end
        checks++;
        if (acc != 8) begin failures++; $display("FAIL bp_accepted: got %0d expected 8", acc); end
        checks++;
        if (in_if.rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy: got %0b expected 0", in_if.rdy); end
        checks++;
        if (dut.fifo_count !== 4'd8) begin failures++; $display("FAIL bp_fifo_full: got %0d expected 8", dut.fifo_count); end
        pops0 = n_pop;
        @(negedge clk);
        in_if.val  = 1'b0;
        out_if.rdy = 1'b1;
        drain("bp");
        checks++;
        if (n_pop - pops0 != 8) begin failures++; $display("FAIL bp_drained: got %0d expected 8", n_pop - pops0); end
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL bp_err: got %0b expected 0", o_err); end
    endtask

    task automatic test_random();
        int issued = 0;
        int cyc    = 0;
        int iss0   = n_issue;
        int pops0  = n_pop;
        while (issued < 1000 && cyc < 20000) begin
            @(negedge clk);
            in_if.val  = 1'b1;
            in_if.dat  = {32'hC0DE0000, 32'(issued)};
            in_if.ctl  = 16'(issued ^ 16'h5A5A);
            out_if.rdy = 1'($urandom_range(0, 1));
            #4;
            if (in_if.rdy === 1'b1) issued++;
            cyc++;
        end
        @(negedge clk);
        in_if.val  = 1'b0;
        out_if.rdy = 1'b1;
        drain("random");
        checks++;
        if (n_issue - iss0 != 1000) begin failures++; $display("FAIL random_issued: got %0d expected 1000", n_issue - iss0); end
        checks++;
        if (n_pop - pops0 != 1000) begin failures++; $display("FAIL random_popped: got %0d expected 1000", n_pop - pops0); end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] head_e;
        @(negedge clk);
        out_if.rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            in_if.val = 1'b1;
            in_if.dat = 64'hB000 + 64'(i);
            in_if.ctl = 16'h200 + 16'(i);
        end
        @(negedge clk);
        in_if.val = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        #4;
        checks++;
        if (dut.fifo_count !== 4'd8 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_setup: got count=%0d err=%0b expected 8 0", dut.fifo_count, o_err);
        end
        head_e = exp_q[0];
        @(negedge clk);
        inj_val = 1'b1;
        inj_dat = 64'hDEAD;
        inj_ctl = 16'hBEEF;
        @(negedge clk);
        inj_val = 1'b0;
        #4;
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL ovf_err_set: got %0b expected 1", o_err); end
        checks++;
        if (dut.fifo_count !== 4'd8 || {out_if.dat, out_if.ctl} !== head_e) begin
            failures++;
            $display("FAIL ovf_contents: got count=%0d head=%0h expected 8 head=%0h",
                     dut.fifo_count, {out_if.dat, out_if.ctl}, head_e);
        end
        @(negedge clk);
        out_if.rdy = 1'b1;
        drain("ovf");
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL ovf_err_sticky: got %0b expected 1", o_err); end
        do_reset();
        #4;
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL ovf_err_cleared: got %0b expected 0", o_err); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        out_if.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            in_if.val = 1'b1;
            in_if.dat = 64'hC00 + 64'(i);
            in_if.ctl = 16'h300 + 16'(i);
        end
        @(negedge clk);
        in_if.val = 1'b0;
        do_reset();
        #4;
        checks++;
        if (dut.cred !== 4'd8 || out_if.val !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state: got cred=%0d val=%0b expected 8 0", dut.cred, out_if.val);
        end
        repeat (LAT + 2) @(negedge clk);
        #4;
        checks++;
        if (out_if.val !== 1'b0) begin failures++; $display("FAIL midrst_discard: got %0b expected 0", out_if.val); end
    endtask

    task automatic test_latency_check();
        @(negedge clk);
        extra      = 1'b1;
        out_if.rdy = 1'b1;
        in_if.val  = 1'b1;
        in_if.dat  = 64'h77;
        in_if.ctl  = 16'h9;
        @(negedge clk);
        in_if.val = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL lat_err_early: got %0b expected 0", o_err); end
        @(negedge clk);
        #4;
`ifdef RESOURCE_CREDIT_LAT_CHK_EN
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL lat_err_set: got %0b expected 1", o_err); end
`else
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL lat_err_absent: got %0b expected 0", o_err); end
`endif
        drain("lat");
        @(negedge clk);
        extra = 1'b0;
        do_reset();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        in_if.val  = 1'b0;
        in_if.dat  = '0;
        in_if.ctl  = '0;
        in_if.sop  = 1'b1;
        in_if.eop  = 1'b1;
        in_if.err  = 1'b0;
        in_if.mod  = '0;
        out_if.rdy = 1'b1;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_overflow();
        test_mid_reset();
        test_latency_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
